// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises external interrupt lines, latches edge/level requests and
// issues one prioritised request pulse to CP0 per ERET handshake.
module irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               eret_ack,
  output logic               ir_out,
  output logic [2:0]         ir_id,
  output logic               busy
);
  // state    | meaning
  // IDLE     | nothing outstanding, arbitrating pending requests
  // REQ      | single ir_out pulse cycle for the claimed source
  // WAIT_ACK | request delivered, holding off until CP0 reports ERET
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;

  state_t                              state;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]                  s;
  logic [NUM_SRC-1:0]                  s_d;
  logic [NUM_SRC-1:0]                  mask;
  logic [NUM_SRC-1:0]                  mode;
  logic [NUM_SRC-1:0]                  pend;
  logic [NUM_SRC-1:0]                  req;
  logic [NUM_SRC-1:0]                  first;
  logic [NUM_SRC-1:0]                  claim;
  logic [NUM_SRC-1:0]                  w1c;
  logic [NUM_SRC-1:0]                  rise;
  logic [2:0]                          sel;
  logic                                unused_wdata;

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign req   = pend & mask;
  // Isolates the lowest set bit; zero when nothing is requested.
  assign first = req & (~req + NUM_SRC'(1));
  assign claim = (state == IDLE) ? (first & mode) : '0;
  assign w1c   = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= '0;
      mask   <= '0;
      mode   <= '0;
      pend   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      s_d    <= s;
      // Edge bits: a new edge beats any clear in the same cycle. Level bits follow s.
      pend   <= (mode & (rise | (pend & ~(w1c | claim)))) | (~mode & s);
      if (cfg_we && cfg_addr == ADDR_MASK) mask <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == ADDR_MODE) mode <= cfg_wdata[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ir_out <= 1'b0;
      ir_id  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ir_id  <= sel;
            ir_out <= 1'b1;
            busy   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          ir_out <= 1'b0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (eret_ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ir_out <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[NUM_SRC-1:0] = mask;
      ADDR_MODE: cfg_rdata[NUM_SRC-1:0] = mode;
      ADDR_PEND: cfg_rdata[NUM_SRC-1:0] = pend;
      default: begin
        cfg_rdata[31]   = busy;
        cfg_rdata[10:8] = ir_id;
        cfg_rdata[1:0]  = state;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the controller.
module tb_irq_ctrl;
  localparam int N  = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [N-1:0] src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        eret_ack;
  logic        ir_out;
  logic [2:0]  ir_id;
  logic        busy;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .eret_ack(eret_ack),
    .ir_out(ir_out), .ir_id(ir_id), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: history of sampled lines, pending bits, service phase.
  logic [7:0] m_hist [SS];
  logic [7:0] m_sd, m_mask, m_mode, m_pend;
  int         m_state;  // 0 idle, 1 pulse cycle, 2 waiting for ERET
  logic [2:0] m_id;
  logic [7:0] t_s, t_req, t_clr, t_np;
  int         t_sel;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SS; k++) m_hist[k] = 8'h0;
      m_sd = 0; m_mask = 0; m_mode = 0; m_pend = 0; m_state = 0; m_id = 0;
    end else begin
      t_s   = m_hist[SS-1];
      t_req = m_pend & m_mask;
      t_sel = -1;
      for (int i = 7; i >= 0; i--) if (t_req[i]) t_sel = i;
      t_clr = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[7:0] : 8'h0;
      if (m_state == 0 && t_sel >= 0) t_clr[t_sel] = 1'b1;
      for (int i = 0; i < 8; i++)
        t_np[i] = m_mode[i] ? ((t_s[i] & ~m_sd[i]) | (m_pend[i] & ~t_clr[i])) : t_s[i];
      case (m_state)
        0: if (t_sel >= 0) begin m_state = 1; m_id = 3'(t_sel); end
        1: m_state = 2;
        default: if (eret_ack) m_state = 0;
      endcase
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[7:0];
      if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_wdata[7:0];
      m_pend = t_np;
      m_sd   = t_s;
      for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = src;
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask};
      2'd1:    return {24'h0, m_mode};
      2'd2:    return {24'h0, m_pend};
      default: return {(m_state != 0), 20'h0, m_id, 6'h0, 2'(m_state)};
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ir_out", 32'(ir_out), 32'(m_state == 1));
      check("model_busy",   32'(busy),   32'(m_state != 0));
      check("model_ir_id",  32'(ir_id),  32'(m_id));
      check("model_rdata",  cfg_rdata,   m_rdata(cfg_addr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(name, cfg_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0; eret_ack = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_ir_out", 32'(ir_out), 0);
    check("rst_busy",   32'(busy),   0);
    rd("rst_status", 2'd3, 32'h0);
    rd("rst_pend",   2'd2, 32'h0);
    rd("rst_mask",   2'd0, 32'h0);

    // Edge source 0: request pulse three edges after the first high sample.
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h01);
    src = 8'h01;
    tick(3);
    check("e_early_ir_out", 32'(ir_out), 0);
    src = 8'h00;
    tick();
    check("e_ir_out", 32'(ir_out), 1);
    check("e_ir_id",  32'(ir_id),  0);
    check("e_busy",   32'(busy),   1);
    tick();
    check("e_pulse_end", 32'(ir_out), 0);
    rd("e_pend",   2'd2, 32'h00);
    rd("e_status", 2'd3, 32'h8000_0002);
    tick(3);
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;
    check("e_ack_busy", 32'(busy), 0);
    rd("e_ack_status", 2'd3, 32'h0);

    // Priority and queueing.
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFF);
    src = 8'h24;
    tick(4);
    check("p_ir_out", 32'(ir_out), 1);
    check("p_ir_id",  32'(ir_id),  2);
    rd("p_pend", 2'd2, 32'h20);
    src = 8'h00;
    tick(3);
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;
    check("p_ack_ir_out", 32'(ir_out), 0);
    check("p_ack_busy",   32'(busy),   0);
    tick();
    check("p_2nd_ir_out", 32'(ir_out), 1);
    check("p_2nd_ir_id",  32'(ir_id),  5);
    rd("p_2nd_status", 2'd3, 32'h8000_0501);
    tick(2);
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;

    // Mask gating, then unmask an already-pending source.
    wr(2'd0, 32'h00);
    src = 8'h08;
    tick(4);
    src = 8'h00;
    check("m_ir_out", 32'(ir_out), 0);
    check("m_busy",   32'(busy),   0);
    rd("m_pend", 2'd2, 32'h08);
    wr(2'd0, 32'h08);
    check("m_wr_ir_out", 32'(ir_out), 0);
    tick();
    check("m_unmask_ir_out", 32'(ir_out), 1);
    check("m_unmask_ir_id",  32'(ir_id),  3);
    tick();
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;

    // Level source re-requests while held, stops once dropped.
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h02);
    src = 8'h02;
    tick(4);
    check("l_ir_out", 32'(ir_out), 1);
    check("l_ir_id",  32'(ir_id),  1);
    tick(2);
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;
    check("l_ack_ir_out", 32'(ir_out), 0);
    tick();
    check("l_rereq_ir_out", 32'(ir_out), 1);
    src = 8'h00;
    tick(4);
    eret_ack = 1'b1; tick(); eret_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("l_drop_ir_out", 32'(ir_out), 0);
    end
    rd("l_drop_pend", 2'd2, 32'h00);

    // W1C colliding with a fresh edge: the edge wins.
    wr(2'd0, 32'h00);
    wr(2'd1, 32'h10);
    src = 8'h10;
    tick(2);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h10;
    tick();
    cfg_we = 1'b0;
    rd("w_collide_pend", 2'd2, 32'h10);
    wr(2'd2, 32'h10);
    rd("w_clear_pend", 2'd2, 32'h00);
    src = 8'h00;
    tick(2);

    // Reset while waiting for ERET with sources pending.
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h07);
    src = 8'h04;
    tick(4);
    check("r_busy",  32'(busy),  1);
    check("r_ir_id", 32'(ir_id), 2);
    src = 8'h07;
    tick(4);
    rd("r_pend", 2'd2, 32'h03);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("r_post_busy",   32'(busy),   0);
    check("r_post_ir_out", 32'(ir_out), 0);
    rd("r_post_pend", 2'd2, 32'h00);
    rd("r_post_mask", 2'd0, 32'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r_quiet_ir_out", 32'(ir_out), 0);
    end
    src = 8'h00;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Multi-source external interrupt controller sitting directly upstream of the CP0 block. It synchronises up to eight asynchronous interrupt lines and latches edge- or level-triggered requests into a pending register. It applies a software mask, selects the highest-priority request and issues a single-cycle request pulse into CP0's `ir_in`. It then holds off further requests until CP0 reports ERET, and exposes mask, mode, pending and status registers to software through a small register port.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..8.
- `SYNC_STAGES`, default 2: synchroniser depth per source, minimum 2.

- `clk`  in  1  main clock.
- `rst_n`  in  1  reset, synchronous, active-low. This is decided.
- `src`  in  NUM_SRC  raw asynchronous interrupt lines, active-high.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  2  register select: 0 MASK, 1 MODE, 2 PENDING, 3 STATUS.
- `cfg_wdata`  in  32  write data; bits [NUM_SRC-1:0] are used.
- `cfg_rdata`  out  32  read data, combinational from `cfg_addr`.
- `eret_ack`  in  1  one-cycle pulse from CP0 when ERET executes.
- `ir_out`  out  1  request pulse, connected to CP0 `ir_in`.
- `ir_id`  out  3  index of the source currently being serviced.
- `busy`  out  1  high from the request until `eret_ack`.

## Operation
- Synchroniser:
  - Each `src[i]` passes through a `SYNC_STAGES` flop chain, producing `s[i]`.
  - A further flop `s_d[i]` holds the previous value for edge detection.
- Pending register `PEND[NUM_SRC-1:0]`:
  - Edge mode (MODE[i]=1): set on `s[i] & ~s_d[i]`. Cleared by a software write-1-to-clear to PENDING, or when the source is claimed.
  - Level mode (MODE[i]=0): `PEND[i]` tracks `s[i]` every cycle. Software clear has no effect.
  - Set and clear in the same cycle: set wins.
- Mask:
  - `req = PEND & MASK`.
  - Masked sources still latch pending; they are delivered once unmasked.
- Priority: lowest index wins. `sel` is the index of the lowest set bit of `req`.
- FSM states IDLE, REQ, WAIT_ACK:
  - IDLE: if `req != 0`, latch `ir_id <= sel`, claim the source (clear `PEND[sel]` if it is edge-mode), then go to REQ. Otherwise stay in IDLE.
  - REQ: `ir_out=1` for exactly this cycle, then go to WAIT_ACK unconditionally.
  - WAIT_ACK: stay until `eret_ack`, then go to IDLE. New requests keep accumulating in PEND meanwhile.
  - `eret_ack` in IDLE or REQ is ignored.
  - `busy` is 1 in REQ and WAIT_ACK.
- Registers:
  - MASK: read/write.
  - MODE: read/write.
  - PENDING: read returns PEND; write is W1C on edge bits.
  - STATUS: read-only. Bit 31 = `busy`, bits [1:0] = FSM state encoding (IDLE=0, REQ=1, WAIT_ACK=2), bits [2:0] of byte 1 = `ir_id`. Writes are ignored.
- Width rules:
  - Bits at and above NUM_SRC read 0 and are ignored on write.
  - `cfg_rdata` upper bits are 0 except STATUS bit 31.
- Changing MASK or MODE while busy does not affect the claimed `ir_id`.
- A level source still asserted after `eret_ack` re-requests on the next IDLE cycle.

## Timing
- Reset values:
  - MASK=0, MODE=0, PEND=0, synchroniser and `s_d` flops = 0, FSM=IDLE.
  - `ir_out=0`, `ir_id=0`, `busy=0`, `cfg_rdata` reflects the zeroed registers.
- `rst_n` low at any clock edge aborts the operation in progress. The FSM returns to IDLE with no further `ir_out` pulse.
- Latency with SYNC_STAGES=2, edge source, masked-in, FSM idle:
  - `src` rises and is sampled at edge E0.
  - `s` is high after E1.
  - PEND bit is set after E2.
  - FSM goes to REQ after E3.
  - `ir_out` is high between E3 and E4.
- Latency grows by one cycle per extra synchroniser stage.
- Unmasking an already-pending source: REQ follows the MASK write edge by one cycle.
- After `eret_ack` is sampled at edge A, FSM is IDLE after A. The earliest next `ir_out` is after A+1.
- `ir_out` is never high two consecutive cycles. At most one pulse is issued per `eret_ack`.
- Register writes take effect at the clock edge where `cfg_we`=1. Reads are same-cycle combinational.

## Test plan
- Reset then edge: `rst_n`=0 for 2 cycles, MASK=0x01, MODE=0x01, pulse `src[0]` for 3 cycles -> `ir_out` high for exactly 1 cycle, 4 edges after the rising sample; `ir_id`=0; PENDING reads 0x00; STATUS bit 31=1 until `eret_ack`.
- Priority and queueing: MASK=0xFF, MODE=0xFF, raise `src[5]` and `src[2]` together -> first `ir_id`=2; PENDING reads 0x20; after `eret_ack`, second `ir_out` with `ir_id`=5, 2 cycles after the ack edge.
- Mask gating: MASK=0x00, edge on `src[3]` -> no `ir_out`, PENDING=0x08; then write MASK=0x08 -> `ir_out` on the following cycle, `ir_id`=3.
- Level re-request: MODE=0x00, MASK=0x02, hold `src[1]` high across `eret_ack` -> a new `ir_out` pulse after each ack. Drop `src[1]` before the ack -> no further pulse.
- W1C versus new edge in the same cycle: write PENDING=0x10 while an edge on `src[4]` is detected -> bit 4 remains set. A later W1C with no new edge clears it (MASK=0 throughout).
- Reset mid-service: in WAIT_ACK with PEND=0x03, assert `rst_n`=0 for 1 cycle -> next cycle `busy`=0, PENDING=0, MASK=0, no `ir_out` pulse.
